// File: rtl/pipe_pkg.sv
// Shared types for the median-filter inter-stage pipeline register.
//   beat_t       : one pipeline beat {mw, row, col, data} at the default widths
//   slot_state_e : occupancy state of one skid slot
//   beat_width() : flattened payload width for arbitrary DATA_W/ADDR_W
package pipe_pkg;

    localparam int unsigned PIPE_DATA_W = 8;
    localparam int unsigned PIPE_ADDR_W = 6;

    // Field order matches the flattened payload {mw, row, col, data}.
    typedef struct packed {
        logic                   mw;
        logic [PIPE_ADDR_W-1:0] row;
        logic [PIPE_ADDR_W-1:0] col;
        logic [PIPE_DATA_W-1:0] data;
    } beat_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_SKID  = 2'd2
    } slot_state_e;

    function automatic int unsigned beat_width(input int unsigned data_w,
                                               input int unsigned addr_w);
        return 1 + 2 * addr_w + data_w;
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One skid-buffer slot: MAIN register drives the downstream side, SKID register
// catches the beat accepted in the cycle downstream stalls.
//   Clock, Reset_n : rising-edge clock, async active-low reset
//   Flush          : sync flush, slot goes EMPTY (payload regs untouched)
//   Up_Valid/Up_Ready/Up_Data : upstream handshake, Up_Ready registered
//   Dn_Valid/Dn_Ready/Dn_Data : downstream handshake, Dn_Valid registered
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int unsigned W = 21
) (
    input  logic         Clock,
    input  logic         Reset_n,
    input  logic         Flush,
    input  logic         Up_Valid,
    output logic         Up_Ready,
    input  logic [W-1:0] Up_Data,
    output logic         Dn_Valid,
    input  logic         Dn_Ready,
    output logic [W-1:0] Dn_Data
);

    slot_state_e  state_q;
    slot_state_e  state_d;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         ready_q;
    logic         valid_q;

    logic         push;
    logic         pop;
    logic         load_main_in;
    logic         load_main_skid;
    logic         load_skid;

    assign push = Up_Valid && ready_q;
    assign pop  = valid_q && Dn_Ready;

    // Next-state and payload load selection.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (Flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (push) begin
                        state_d      = S_FULL;
                        load_main_in = 1'b1;
                    end
                end
                S_FULL: begin
                    if (push && pop) begin
                        load_main_in = 1'b1;
                    end else if (pop) begin
                        state_d = S_EMPTY;
                    end else if (push) begin
                        state_d   = S_SKID;
                        load_skid = 1'b1;
                    end
                end
                S_SKID: begin
                    // Up_Ready is low here, so only a pop can happen.
                    if (pop) begin
                        state_d        = S_FULL;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    // State register plus registered handshake flags decoded from next state.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_EMPTY;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != S_SKID);
            valid_q <= (state_d != S_EMPTY);
        end
    end

    // Payload registers load only on accepted pushes or skid drain.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= Up_Data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= Up_Data;
            end
        end
    end

    assign Up_Ready = ready_q;
    assign Dn_Valid = valid_q;
    assign Dn_Data  = main_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Inter-stage pipeline register for the median-filter datapath: STAGES chained
// skid slots carrying {MemWrite, row, col, data} with valid/ready back-pressure,
// sync flush and an occupancy count. No-stall latency is STAGES cycles.
//   Clock, Reset_n        : rising-edge clock, async active-low reset
//   Flush                 : sync flush, drops every held beat and the offered one
//   In_Valid/In_Ready     : upstream handshake (In_Ready registered)
//   In_MemWrite/Row/Col/Data : upstream beat payload
//   Out_Valid/Out_Ready   : downstream handshake
//   Out_MemWrite          : held MemWrite gated by Out_Valid
//   Out_Row/Col/Data      : payload of the beat at the output
//   Occupancy             : beats held, 0..2*STAGES
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_DATA_W,
    parameter int unsigned ADDR_W = PIPE_ADDR_W,
    parameter int unsigned STAGES = 1
) (
    input  logic                             Clock,
    input  logic                             Reset_n,
    input  logic                             Flush,
    input  logic                             In_Valid,
    output logic                             In_Ready,
    input  logic                             In_MemWrite,
    input  logic [ADDR_W-1:0]                In_Row,
    input  logic [ADDR_W-1:0]                In_Col,
    input  logic [DATA_W-1:0]                In_Data,
    output logic                             Out_Valid,
    input  logic                             Out_Ready,
    output logic                             Out_MemWrite,
    output logic [ADDR_W-1:0]                Out_Row,
    output logic [ADDR_W-1:0]                Out_Col,
    output logic [DATA_W-1:0]                Out_Data,
    output logic [$clog2(2*STAGES+1)-1:0]    Occupancy
);

    localparam int unsigned BEAT_W = beat_width(DATA_W, ADDR_W);
    localparam int unsigned OCC_W  = $clog2(2 * STAGES + 1);

    // Handshake chain: index k is the input side of slot k, STAGES is the output.
    logic              chain_valid [STAGES+1];
    logic              chain_ready [STAGES+1];
    logic [BEAT_W-1:0] chain_data  [STAGES+1];

    logic              held_mw;
    logic              in_fire;
    logic              out_fire;
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_d;

    assign chain_valid[0]      = In_Valid;
    assign chain_data[0]       = {In_MemWrite, In_Row, In_Col, In_Data};
    assign chain_ready[STAGES] = Out_Ready;
    assign In_Ready            = chain_ready[0];

    // Slot k feeds slot k+1.
    for (genvar k = 0; k < STAGES; k++) begin : g_slot
        pipe_skid_slot #(
            .W (BEAT_W)
        ) u_slot (
            .Clock    (Clock),
            .Reset_n  (Reset_n),
            .Flush    (Flush),
            .Up_Valid (chain_valid[k]),
            .Up_Ready (chain_ready[k]),
            .Up_Data  (chain_data[k]),
            .Dn_Valid (chain_valid[k+1]),
            .Dn_Ready (chain_ready[k+1]),
            .Dn_Data  (chain_data[k+1])
        );
    end

    assign Out_Valid = chain_valid[STAGES];
    assign {held_mw, Out_Row, Out_Col, Out_Data} = chain_data[STAGES];

    // No memory write may leak out while the output holds no beat.
    assign Out_MemWrite = held_mw & Out_Valid;

    assign in_fire  = In_Valid && chain_ready[0];
    assign out_fire = Out_Valid && Out_Ready;

    // Occupancy next value; simultaneous in and out transfers cancel.
    always_comb begin
        occ_d = occ_q;
        if (Flush) begin
            occ_d = '0;
        end else if (in_fire && !out_fire) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (out_fire && !in_fire) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign Occupancy = occ_q;

endmodule
